// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with a memory-ready handshake, illegal-opcode trapping and a retired-instruction counter.
module multicycle_control #(
   parameter int OPW    = 6,
   parameter int CNT_W  = 16,
   parameter int MEM_HS = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OPW-1:0]   opcode,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             PCWriteCondNot,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       AluOP,
   output logic [1:0]       PCSource,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       state
);

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RWB    = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_BEQ    = 4'd11,
      S_BNE    = 4'd12,
      S_JUMP   = 4'd13,
      S_TRAP   = 4'd14,
      S_BAD    = 4'd15
   } state_t;

   // Opcodes are zero-extended so any set upper bit falls through to TRAP.
   localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
   localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
   localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
   localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
   localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
   localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
   localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_count;
   logic               w_ready;
   logic               w_retire;

   assign w_ready     = (MEM_HS != 0) ? mem_ready : 1'b1;
   assign state       = r_state;
   assign instr_count = r_count;

   always_comb begin
      // NOTE: default first so every path assigns w_next and no latch is inferred.
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     w_next = S_EXEC;
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_BEQ:       w_next = S_BEQ;
               OP_BNE:       w_next = S_BNE;
               OP_J:         w_next = S_JUMP;
               default:      w_next = S_TRAP;
            endcase
         end
         S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  w_next = w_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   w_next = S_RWB;
         S_ADDIEX: w_next = S_ADDIWB;
         default:  w_next = S_FETCH;
      endcase
   end

   always_comb begin
      case (r_state)
         S_MEMWB, S_RWB, S_ADDIWB, S_BEQ, S_BNE, S_JUMP: w_retire = 1'b1;
         S_MEMWR: w_retire = w_ready;
         default: w_retire = 1'b0;
      endcase
   end

   // NOTE: state and counter use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RST;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) r_count <= r_count + CNT_W'(1);
      end
   end

   // Outputs decode from the state register alone (plus mem_ready in FETCH), so an
   // asynchronous reset clears every strobe immediately.
   always_comb begin
      PCWrite        = 1'b0;
      PCWriteCond    = 1'b0;
      PCWriteCondNot = 1'b0;
      IorD           = 1'b0;
      MemRead        = 1'b0;
      MemWrite       = 1'b0;
      IRWrite        = 1'b0;
      MemtoReg       = 1'b0;
      RegDst         = 1'b0;
      RegWrite       = 1'b0;
      ALUSrcA        = 1'b0;
      ALUSrcB        = 2'b00;
      AluOP          = 2'b00;
      PCSource       = 2'b00;
      illegal        = 1'b0;
      case (r_state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = w_ready;
            PCWrite = w_ready;
         end
         S_DECODE: ALUSrcB = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            AluOP   = 2'b10;
         end
         S_RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_ADDIWB: RegWrite = 1'b1;
         S_BEQ: begin
            ALUSrcA     = 1'b1;
            AluOP       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
         end
         S_BNE: begin
            ALUSrcA        = 1'b1;
            AluOP          = 2'b01;
            PCWriteCondNot = 1'b1;
            PCSource       = 2'b01;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
         end
         S_TRAP: illegal = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS main decoder.
- Moore FSM that sequences one instruction over 3–5 states: fetch, decode, execute, memory, writeback.
- Drives datapath enables, mux selects and AluOP for the shared-ALU/shared-memory datapath.
- Adds a memory ready handshake, illegal-opcode trapping and a retired-instruction counter.

Parameters:
- OPW, 6, opcode width; opcodes below are defined in their low 6 bits, upper bits must be 0 to match.
- CNT_W, 16, width of the retired-instruction counter.
- MEM_HS, 1, 1 = wait on mem_ready in memory states; 0 = mem_ready treated as constant 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPW  IR[31:26]; stable from the cycle after IRWrite.
- mem_ready  in  1  memory completes the access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero (beq).
- PCWriteCondNot  out  1  PC load if ALU not zero (bne).
- IorD  out  1  memory address mux: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  write-back data mux: 1 = MDR.
- RegDst  out  1  destination register mux: 1 = rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A mux: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B mux: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2.
- AluOP  out  2  00 = add, 01 = sub, 10 = funct.
- PCSource  out  2  PC mux: 00 = ALU, 01 = ALUOut, 10 = jump target.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- instr_count  out  CNT_W  retired instructions.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset
  - rst_n low forces state = RST (0) asynchronously and instr_count = 0.
  - In RST every output is 0.
  - RST moves to FETCH on the first clk edge with rst_n high.
- Outputs are pure functions of state and mem_ready; they take no opcode term. Every output not listed for a state is 0.
- State encoding and actions:
  - FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluOP=00, PCSource=00. IRWrite and PCWrite equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, AluOP=00. Next state by opcode:
    - 000000 → EXEC
    - 100011 or 101011 → MEMADR
    - 001000 → ADDIEX
    - 000100 → BEQ
    - 000101 → BNE
    - 000010 → JUMP
    - any other opcode → TRAP
  - MEMADR(3): ALUSrcA=1, ALUSrcB=10, AluOP=00. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD(4): MemRead=1, IorD=1. Hold while mem_ready=0, then go to MEMWB.
  - MEMWB(5): RegWrite=1, MemtoReg=1, RegDst=0. Retires; go to FETCH.
  - MEMWR(6): MemWrite=1, IorD=1. Hold while mem_ready=0; retires on the mem_ready=1 cycle; go to FETCH.
  - EXEC(7): ALUSrcA=1, ALUSrcB=00, AluOP=10. Go to RWB.
  - RWB(8): RegWrite=1, RegDst=1, MemtoReg=0. Retires; go to FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, AluOP=00. Go to ADDIWB.
  - ADDIWB(10): RegWrite=1, RegDst=0, MemtoReg=0. Retires; go to FETCH.
  - BEQ(11): ALUSrcA=1, ALUSrcB=00, AluOP=01, PCWriteCond=1, PCSource=01. Retires; go to FETCH.
  - BNE(12): same as BEQ but drives PCWriteCondNot=1 instead of PCWriteCond. Retires; go to FETCH.
  - JUMP(13): PCWrite=1, PCSource=10. Retires; go to FETCH.
  - TRAP(14): illegal=1. Does not retire; go to FETCH.
  - Encodings 0 and 15 are illegal states and fall back to FETCH. State 0 is RST, which goes to FETCH. State 15 goes to FETCH with all outputs 0.
- Cycle counts with mem_ready held at 1:
  - R-type 4, lw 5, sw 4, addi 4, beq/bne/j 3, illegal 3.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Memory strobes hold steady through waits: MemRead/MemWrite stay high and IorD stays stable for every wait cycle.
- Retire counter:
  - instr_count increments by 1 on the clk edge that leaves a retiring state (for MEMWR, the mem_ready=1 edge).
  - Wraps modulo 2^CNT_W.
  - The opcode is sampled in DECODE and MEMADR only.
- Reset mid-instruction: takes effect immediately, with no partial retire. Any pending MemWrite drops asynchronously.

Test Plan:
- Reset, then R-type opcode 000000 with mem_ready=1 → states 1,2,7,8,1. RegWrite=1 and RegDst=1 only in state 8. instr_count=1.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD → FETCH held 3 cycles and IRWrite=1 only on the last. MEMRD held 4 cycles. Total 10 cycles; instr_count +1.
- sw, then beq, bne and j back-to-back → MemWrite=1 only in state 6. PCWriteCond=1 only in 11, PCWriteCondNot=1 only in 12, PCWrite=1 with PCSource=10 in 13. instr_count=4.
- Opcode 111111 → TRAP for one cycle with illegal=1, then FETCH. instr_count unchanged.
- CNT_W=2 with 5 addi instructions → instr_count sequence 1,2,3,0,1.
- Reset asserted during MEMWR with mem_ready=0 → MemWrite drops in the same cycle. state=0 and instr_count=0 until rst_n rises; the next state is FETCH.
